// File: rtl/psum_pkg.sv
// Shared sizing and FSM encoding for the partial-sum accumulate path.
package psum_pkg;
  localparam int PSUM_DATA_W = 128;
  localparam int PSUM_LANES  = 8;
  localparam int PSUM_LANE_W = PSUM_DATA_W / PSUM_LANES;
  localparam int PSUM_ADDR_W = 9;
  localparam int PSUM_DEPTH  = 324;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } psum_state_e;
endpackage

// File: rtl/psum_lane_add.sv
// Lane-wise wrap adder: each LANE_W slice adds independently, no carry between lanes.
module psum_lane_add
  import psum_pkg::*;
#(
  parameter int LANES  = PSUM_LANES,
  parameter int LANE_W = PSUM_LANE_W
) (
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  output logic [LANES*LANE_W-1:0] sum
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sum[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] + b[i*LANE_W +: LANE_W];
  end
endmodule

// File: rtl/psum_accum_ctrl.sv
// Read-modify-write sequencer for the partial-sum BRAM: stage 0 accepts a row and
// issues the read, stage 1 adds and writes back, last pass also streams results out.
module psum_accum_ctrl
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH = PSUM_DATA_W,
  parameter int LANES      = PSUM_LANES,
  parameter int ADDR_WIDTH = PSUM_ADDR_W,
  parameter int DEPTH      = PSUM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_entries,
  input  logic                  first_pass,
  input  logic                  last_pass,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  bram_we_a,
  output logic [ADDR_WIDTH-1:0] bram_addr_a,
  output logic [DATA_WIDTH-1:0] bram_din_a,
  output logic                  bram_en_b,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  input  logic [DATA_WIDTH-1:0] bram_dout_b
);
  psum_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] n_reg, rd_cnt, s1_addr, n_clamp;
  logic                  fp_reg, lp_reg;
  logic                  s1_vld, out_vld, fwd_hit;
  logic [DATA_WIDTH-1:0] s1_row, fwd_data, out_q;
  logic [DATA_WIDTH-1:0] rd_data, add_sum, sum;
  logic                  stall, accept, s1_fire, last_row;

  assign n_clamp  = (num_entries > ADDR_WIDTH'(DEPTH)) ? ADDR_WIDTH'(DEPTH) : num_entries;
  assign stall    = lp_reg & out_vld & ~out_ready & s1_vld;
  assign in_ready = (state == ST_RUN) & ~stall;
  assign accept   = in_valid & in_ready;
  assign s1_fire  = s1_vld & ~stall;
  assign last_row = (rd_cnt == n_reg - ADDR_WIDTH'(1));

  // A write to the address being read this cycle would be missed by the BRAM read,
  // so the written sum is captured and substituted one cycle later.
  assign rd_data = fwd_hit ? fwd_data : bram_dout_b;

  psum_lane_add #(
    .LANES (LANES),
    .LANE_W(DATA_WIDTH / LANES)
  ) u_add (
    .a  (rd_data),
    .b  (s1_row),
    .sum(add_sum)
  );

  assign sum = fp_reg ? s1_row : add_sum;

  assign bram_en_b   = accept & ~fp_reg;
  assign bram_addr_b = bram_en_b ? rd_cnt : '0;
  assign bram_we_a   = s1_fire;
  assign bram_addr_a = s1_fire ? s1_addr : '0;
  assign bram_din_a  = s1_fire ? sum : '0;

  assign busy      = (state == ST_RUN) | (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign out_valid = out_vld;
  assign out_data  = out_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (n_clamp == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (accept && last_row) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!s1_vld && !out_vld) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      n_reg    <= '0;
      fp_reg   <= 1'b0;
      lp_reg   <= 1'b0;
      rd_cnt   <= '0;
      s1_vld   <= 1'b0;
      s1_addr  <= '0;
      s1_row   <= '0;
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
      out_vld  <= 1'b0;
      out_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        n_reg  <= n_clamp;
        fp_reg <= first_pass;
        lp_reg <= last_pass;
        rd_cnt <= '0;
      end else if (accept) begin
        rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
      end

      // Stage 1 holds its row (and the BRAM holds dout) for the whole stall.
      if (!stall) begin
        s1_vld <= accept;
        if (accept) begin
          s1_addr  <= rd_cnt;
          s1_row   <= in_data;
          fwd_hit  <= s1_fire & (s1_addr == rd_cnt);
          fwd_data <= sum;
        end
      end

      if (s1_fire && lp_reg) begin
        out_vld <= 1'b1;
        out_q   <= sum;
      end else if (out_ready) begin
        out_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Self-checking bench: behavioural BRAM plus a per-address array model of the stored sums.
module tb_psum_accum_ctrl;
  localparam int DW = 128, AW = 9, DEPTH = 324, LW = 16, LANES = 8;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          start = 1'b0, first_pass = 1'b0, last_pass = 1'b0;
  logic [AW-1:0] num_entries = '0;
  logic          busy, done, in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          bram_we_a, bram_en_b;
  logic [AW-1:0] bram_addr_a, bram_addr_b;
  logic [DW-1:0] bram_din_a, bram_dout_b;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] rows_in [DEPTH];
  logic          mem_clr = 1'b1;
  int            n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  psum_accum_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_entries(num_entries),
    .first_pass(first_pass), .last_pass(last_pass), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a), .bram_din_a(bram_din_a),
    .bram_en_b(bram_en_b), .bram_addr_b(bram_addr_b), .bram_dout_b(bram_dout_b)
  );

  // Simple dual-port BRAM, read-before-write on a same-address collision.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bram_dout_b <= '0;
    end else begin
      if (bram_we_a) mem[bram_addr_a] <= bram_din_a;
      if (bram_en_b) bram_dout_b <= mem[bram_addr_b];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int unsigned   x;
    for (int i = 0; i < LANES; i++) begin
      x = (int'(a[i*LW +: LW]) + int'(b[i*LW +: LW])) % 65536;
      r[i*LW +: LW] = LW'(x);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] splat(input int v);
    logic [LW-1:0] h;
    h = LW'(v);
    return {LANES{h}};
  endfunction

  task automatic rand_rows(input int n);
    for (int i = 0; i < n; i++) rows_in[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // rmode: 0 ready always, 1 random ready, 2 ready low for iterations 6..8.
  // abort_at > 0 pulls reset as soon as that many rows have been accepted.
  task automatic run_pass(input string nm, input int n, input bit fp, input bit lp,
                          input int rmode, input int gap_pct, input int abort_at);
    int            nrows, k, nw, no, nen, acc_it, done_it, budget;
    logic [DW-1:0] exp_v [$];
    bit            prev_hold, prev_iv;
    logic [DW-1:0] prev_od;
    nrows = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < nrows; i++)
      exp_v.push_back(fp ? rows_in[i] : lane_sum(ref_mem[i], rows_in[i]));
    k = 0; nw = 0; no = 0; nen = 0; acc_it = -1; done_it = -1;
    prev_hold = 1'b0; prev_iv = 1'b0; prev_od = '0;
    budget = 6 * nrows + 40;
    for (int it = 0; it < budget; it++) begin
      @(negedge clk);
      start       = (it == 0);
      num_entries = AW'(n);
      first_pass  = fp;
      last_pass   = lp;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(it >= 6 && it < 9);
      endcase
      in_valid = (it > 0) && (k < nrows) && ($urandom_range(0, 99) >= gap_pct);
      in_data  = in_valid ? rows_in[k] : {$urandom, $urandom, $urandom, $urandom};
      if (abort_at > 0 && k == abort_at) begin
        reset_n = 1'b0; in_valid = 1'b0; start = 1'b0;
        #1;
        chk({nm, ":rst_ctl"}, DW'({busy, done, in_ready, out_valid, bram_we_a, bram_en_b}), '0);
        chk({nm, ":rst_bus"}, out_data | bram_din_a | DW'({bram_addr_a, bram_addr_b}), '0);
        break;
      end
      #1;
      if (it == 0) chk({nm, ":idle"}, DW'({busy, done}), '0);
      if (bram_we_a) begin
        if (nw < nrows) begin
          chk({nm, ":wr_addr"}, DW'(bram_addr_a), DW'(nw));
          chk({nm, ":wr_data"}, bram_din_a, exp_v[nw]);
        end else chk({nm, ":wr_extra"}, DW'(nw), DW'(nrows));
        nw++;
      end
      if (bram_en_b) begin
        chk({nm, ":rd_addr"}, DW'(bram_addr_b), DW'(k));
        nen++;
      end
      if (prev_hold) begin
        chk({nm, ":hold_v"}, DW'(out_valid), DW'(1));
        chk({nm, ":hold_d"}, out_data, prev_od);
        if (prev_iv && !out_ready) chk({nm, ":stall_rdy"}, DW'(in_ready), '0);
      end
      if (out_valid && out_ready) begin
        if (lp && no < nrows) chk({nm, ":out_data"}, out_data, exp_v[no]);
        else chk({nm, ":out_extra"}, DW'(no), DW'(nrows));
        no++;
      end
      prev_hold = out_valid && !out_ready;
      prev_iv   = in_valid;
      prev_od   = out_data;
      if (done) begin
        done_it = it;
        break;
      end
      if (in_valid && in_ready) begin
        acc_it = it;
        k++;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    if (abort_at > 0) begin
      @(negedge clk);
      reset_n = 1'b1;
      chk({nm, ":abort_wr"}, DW'(nw), DW'(abort_at - 1));
      for (int i = 0; i < abort_at - 1; i++) ref_mem[i] = exp_v[i];
    end else begin
      chk({nm, ":done_seen"}, DW'(done_it >= 0), DW'(1));
      chk({nm, ":n_wr"}, DW'(nw), DW'(nrows));
      chk({nm, ":n_out"}, DW'(no), DW'(lp ? nrows : 0));
      chk({nm, ":n_rd"}, DW'(nen), DW'(fp ? 0 : nrows));
      if (rmode == 0)
        chk({nm, ":done_lat"}, DW'(nrows == 0 ? done_it : done_it - acc_it),
            DW'(nrows == 0 ? 1 : (lp ? 4 : 3)));
      for (int i = 0; i < nrows; i++) ref_mem[i] = exp_v[i];
    end
    for (int i = 0; i < nrows; i++) chk({nm, ":mem"}, mem[i], ref_mem[i]);
  endtask

  initial begin
    logic [DW-1:0] a, b, e;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      rows_in[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ctl", DW'({busy, done, in_ready, out_valid, bram_we_a, bram_en_b}), '0);
    chk("reset_bus", out_data | bram_din_a | DW'({bram_addr_a, bram_addr_b}), '0);
    mem_clr = 1'b0;
    reset_n = 1'b1;

    // Overwrite pass, then accumulate-and-emit pass on the same rows.
    for (int i = 0; i < 4; i++) rows_in[i] = splat(i + 1);
    run_pass("t1", 4, 1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) rows_in[i] = splat(2);
    run_pass("t2", 4, 1'b0, 1'b1, 0, 0, 0);
    chk("t2_row3", mem[3], splat(6));

    // Lane wrap: only the targeted lanes change.
    a = splat(16'h1234); a[3*LW +: LW] = 16'h7FFF; a[5*LW +: LW] = 16'hFFFF;
    rows_in[0] = a;
    run_pass("t3a", 1, 1'b1, 1'b0, 0, 0, 0);
    b = '0; b[3*LW +: LW] = 16'h0001; b[5*LW +: LW] = 16'h0001;
    rows_in[0] = b;
    run_pass("t3b", 1, 1'b0, 1'b1, 0, 0, 0);
    e = splat(16'h1234); e[3*LW +: LW] = 16'h8000; e[5*LW +: LW] = 16'h0000;
    chk("t3_wrap", mem[0], e);

    // Back-to-back single-row passes on the same address.
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    rows_in[0] = a;
    run_pass("t4a", 1, 1'b1, 1'b0, 0, 0, 0);
    rows_in[0] = b;
    run_pass("t4b", 1, 1'b0, 1'b1, 0, 0, 0);
    chk("t4_sum", mem[0], lane_sum(a, b));

    rand_rows(8);
    run_pass("t5", 8, 1'b0, 1'b1, 2, 0, 0);

    rand_rows(6);
    run_pass("t6", 6, 1'b0, 1'b0, 0, 0, 2);
    run_pass("t6_n0", 0, 1'b0, 1'b0, 0, 0, 0);

    rand_rows(DEPTH);
    run_pass("clamp", 400, 1'b1, 1'b0, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 40);
      rand_rows(n);
      run_pass("rnd", n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 30, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
